dipsw_select_filter: RTL and testbench
======================================

Name: dipsw_select_filter

Overview:
- Front-end stage for the dot-matrix digit display. It synchronises and debounces the 8 raw DIP switches.
- It validates that exactly one switch is on and presents a clean, stable one-hot select to the downstream dot-matrix driver's dipsw input.
- It also reports the select index, a change pulse and an invalid-pattern flag.

Parameters:
STABLE_CNT, 54000, consecutive clk cycles the synchronised switch word must stay unchanged before it is committed (legal range 1 to 2^20-1)
SW_W, 8, number of switches, fixed at 8 in this design

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
dipsw  input  8  raw asynchronous switch levels, bit i = switch i+1
sel  output  8  committed one-hot select; 8'h00 = blank; feeds driver dipsw
sel_idx  output  3  binary index of the set bit in sel; 0 when sel is 0
sel_vld  output  1  1 when sel holds exactly one set bit
changed  output  1  one-cycle pulse on every commit that alters sel
err  output  1  1 while the last committed word had two or more bits set

Behaviour:
- Reset:
  - Asynchronous; asserting reset clears everything immediately, including mid-count: sync regs, cand, cnt, state, sel, sel_idx, sel_vld, changed, err all go to 0 and state to IDLE.
  - Deassertion takes effect at the next clk edge.
  - After release, the first commit happens only after a full stable window.
- Synchroniser: two-flop chain on all 8 bits, giving s1 and then s2. The chain adds 2 cycles of latency.
- Candidate register and counter:
  - cand is 8 bits. cnt is a counter sized to hold STABLE_CNT-1.
  - FSM states: IDLE (nothing pending), COUNT (window running), COMMIT (single-cycle commit).
- Every edge, s2 != cand has priority in all states:
  - cand <= s2, cnt <= 0, state <= COUNT.
  - A bounce mid-window therefore restarts the window.
- COUNT with s2 == cand:
  - If cnt == STABLE_CNT-1, go to COMMIT.
  - Otherwise cnt <= cnt+1.
- COMMIT (when s2 == cand): evaluate cand, then go to IDLE.
  - Popcount 1: sel <= cand, sel_idx <= position of the set bit, sel_vld <= 1, err <= 0.
  - Popcount 0: sel <= 0, sel_idx <= 0, sel_vld <= 0, err <= 0.
  - Popcount 2 or more: sel, sel_idx and sel_vld hold their previous values; err <= 1.
  - changed <= 1 for exactly one cycle when the new sel differs from the old sel. There is no pulse on an err-only commit or on re-committing the same value.
- IDLE with s2 == cand: no activity, all outputs held, changed = 0.
- Latency:
  - A dipsw change is sampled into s1 at edge N.
  - cand loads at edge N+2, and outputs update at edge N+2+STABLE_CNT.
  - Example: STABLE_CNT=4 gives an update at N+6.
- changed is registered and 0 in every cycle other than the commit cycle.
- All outputs are registered; there are no combinational paths from dipsw.

Decomposition:
- Shared package dot_pkg holds:
  - SW_W = 8 and IDX_W = 3.
  - DEF_STABLE_CNT = 54000.
  - State encoding for the 3 states: IDLE = 2'd0, COUNT = 2'd1, COMMIT = 2'd2.
  - Blank code 8'h00.
- One natural sub-module, sync2: a parameterised-width two-flop synchroniser with async active-high reset.
- Popcount and index encoding stay inline.

Test Plan (STABLE_CNT=4 unless noted):
- Power-on: hold reset 3 cycles with dipsw=8'h04, then release and hold dipsw. Required: all outputs 0 during reset; at the 6th edge after release, sel=8'h04, sel_idx=2, sel_vld=1, changed pulses 1 cycle, err=0.
- Bounce: from sel=8'h04, toggle dipsw 8'h04→8'h10→8'h04→8'h10 with 2-cycle gaps, then hold 8'h10. Required: no commit during toggling; sel=8'h10, sel_idx=4 exactly 6 edges after the final change; single changed pulse.
- Multi-bit: from sel=8'h10, apply 8'h12 and hold. Required: err=1 after 6 edges, sel stays 8'h10, sel_vld=1, no changed pulse. Then apply 8'h80. Required: err=0, sel=8'h80, sel_idx=7, changed pulse.
- Blank: from sel=8'h80, apply 8'h00. Required: sel=8'h00, sel_idx=0, sel_vld=0, err=0, changed pulse. Then re-apply 8'h00 with a 1-cycle glitch to 8'h01. Required: no changed pulse, sel stays 8'h00.
- Reset mid-window: apply 8'h01, assert reset 2 edges later. Required: outputs 0 immediately, asynchronously. Release with 8'h01 held. Required: commit 6 edges after release, sel=8'h01, sel_idx=0.
- Sweep: with STABLE_CNT=1, walk all 8 one-hot values, each held 10 cycles. Required: sel_idx=0..7 in order, 3-edge latency each, 8 changed pulses.

Source files
------------

// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
//   Shared constants for the dot-matrix display front end.
//   SW_W           : number of DIP switches (fixed at 8)
//   IDX_W          : width of the binary select index
//   DEF_STABLE_CNT : default debounce window in clk cycles
//   ST_*           : filter FSM state codes
//   BLANK          : select word that blanks the display
// -----------------------------------------------------------------------------
package dot_pkg;

    localparam int unsigned SW_W           = 8;
    localparam int unsigned IDX_W          = 3;
    localparam int unsigned DEF_STABLE_CNT = 54000;

    localparam logic [1:0] ST_IDLE   = 2'd0;  // nothing pending
    localparam logic [1:0] ST_COUNT  = 2'd1;  // stability window running
    localparam logic [1:0] ST_COMMIT = 2'd2;  // single-cycle commit

    localparam logic [SW_W-1:0] BLANK = 8'h00;

    typedef logic [SW_W-1:0]  sw_word_t;
    typedef logic [IDX_W-1:0] sw_idx_t;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchroniser for a bus of independent asynchronous levels.
//   Ports:
//     clk   : destination clock
//     rst   : asynchronous active-high reset, clears both stages
//     d_i   : asynchronous input levels
//     q_o   : synchronised levels, two cycles behind d_i
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/dipsw_select_filter.sv
// -----------------------------------------------------------------------------
// dipsw_select_filter
//   Synchronises and debounces the 8 raw DIP switches and presents a stable
//   one-hot select to the dot-matrix driver.
//   Ports:
//     clk     : system clock
//     reset   : asynchronous active-high reset
//     dipsw   : raw switch levels, bit i = switch i+1
//     sel     : committed one-hot select, 8'h00 = blank
//     sel_idx : binary index of the set bit in sel, 0 when sel is blank
//     sel_vld : sel holds exactly one set bit
//     changed : one-cycle pulse on every commit that alters sel
//     err     : last committed word had two or more bits set
// -----------------------------------------------------------------------------
module dipsw_select_filter
    import dot_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  dipsw,
    output logic [SW_W-1:0]  sel,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_vld,
    output logic             changed,
    output logic             err
);

    localparam int unsigned CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam int unsigned POP_W = $clog2(SW_W + 1);

    sw_word_t         s2;

    sw_word_t         cand_q,    cand_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       state_q,   state_d;
    sw_word_t         sel_q,     sel_d;
    sw_idx_t          idx_q,     idx_d;
    logic             vld_q,     vld_d;
    logic             changed_q, changed_d;
    logic             err_q,     err_d;

    logic [POP_W-1:0] pop;
    sw_idx_t          pos;

    sync2 #(
        .W (SW_W)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .d_i (dipsw),
        .q_o (s2)
    );

    // Population count of the candidate and position of its highest set bit;
    // the position is only used when exactly one bit is set.
    always_comb begin
        pop = '0;
        pos = '0;
        for (int unsigned i = 0; i < SW_W; i++) begin
            if (cand_q[i]) begin
                pop = pop + POP_W'(1);
                pos = IDX_W'(i);
            end
        end
    end

    // The output registers load on the edge that enters COMMIT, so the
    // committed word appears STABLE_CNT edges after cand loads; the COMMIT
    // cycle is the cycle in which the changed pulse is visible.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        err_d     = err_q;
        changed_d = 1'b0;

        if (s2 != cand_q) begin
            // Any movement of the synchronised word restarts the window.
            cand_d  = s2;
            cnt_d   = '0;
            state_d = ST_COUNT;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_COMMIT;
                        if (pop == POP_W'(1)) begin
                            sel_d     = cand_q;
                            idx_d     = pos;
                            vld_d     = 1'b1;
                            err_d     = 1'b0;
                            changed_d = (cand_q != sel_q);
                        end else if (pop == '0) begin
                            sel_d     = BLANK;
                            idx_d     = '0;
                            vld_d     = 1'b0;
                            err_d     = 1'b0;
                            changed_d = (sel_q != BLANK);
                        end else begin
                            // Illegal multi-switch pattern: keep the last
                            // good select, only flag the error.
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= BLANK;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            changed_q <= changed_d;
            err_q     <= err_d;
        end
    end

    assign sel     = sel_q;
    assign sel_idx = idx_q;
    assign sel_vld = vld_q;
    assign changed = changed_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dipsw_select_filter.sv
// -----------------------------------------------------------------------------
// tb_dipsw_select_filter
//   Two instances: A with STABLE_CNT=4, B with STABLE_CNT=1, sharing clk and
//   reset. Expected outputs come from a run-length model: a value sampled at
//   edge N is committed at edge N+2+STABLE_CNT when it has been sampled
//   without interruption for STABLE_CNT+1 consecutive edges.
//   Output words are packed as {sel, sel_idx, sel_vld, changed, err}.
// -----------------------------------------------------------------------------
module tb_dipsw_select_filter;

    localparam int SA = 4;
    localparam int SB = 1;

    logic       clk;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic [7:0] sel_a, sel_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b, chg_a, chg_b, err_a, err_b;
    logic [14:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    dipsw_select_filter #(.STABLE_CNT(SA)) u_dut_a (
        .clk(clk), .reset(reset), .dipsw(din_a),
        .sel(sel_a), .sel_idx(idx_a), .sel_vld(vld_a), .changed(chg_a), .err(err_a)
    );

    dipsw_select_filter #(.STABLE_CNT(SB)) u_dut_b (
        .clk(clk), .reset(reset), .dipsw(din_b),
        .sel(sel_b), .sel_idx(idx_b), .sel_vld(vld_b), .changed(chg_b), .err(err_b)
    );

    assign obs_a = {sel_a, idx_a, vld_a, chg_a, err_a};
    assign obs_b = {sel_b, idx_b, vld_b, chg_b, err_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_sel[2];
    logic [2:0] m_idx[2];
    logic       m_vld[2], m_chg[2], m_err[2];
    logic [7:0] m_d1[2], m_d2[2], m_last[2];
    int         m_run[2];

    function automatic int stab_of(int k);
        return (k == 0) ? SA : SB;
    endfunction

    function automatic logic [14:0] exp_w(int k);
        return {m_sel[k], m_idx[k], m_vld[k], m_chg[k], m_err[k]};
    endfunction

    function automatic logic [14:0] mk(logic [7:0] s, logic [2:0] i, logic v, logic c, logic e);
        return {s, i, v, c, e};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = '0; m_idx[k] = '0; m_vld[k] = 1'b0; m_chg[k] = 1'b0; m_err[k] = 1'b0;
            m_d1[k] = '0; m_d2[k] = '0; m_last[k] = '0;
            m_run[k] = stab_of(k) + 2;  // the post-reset zero word never commits
        end
    endtask

    task automatic model_edge(int k, logic [7:0] samp);
        logic [7:0] d;
        d = m_d2[k];               // word sampled two edges ago
        m_d2[k] = m_d1[k];
        m_d1[k] = samp;
        m_chg[k] = 1'b0;
        if (d == m_last[k]) begin
            if (m_run[k] < stab_of(k) + 2) m_run[k]++;
        end else begin
            m_last[k] = d;
            m_run[k] = 1;
        end
        if (m_run[k] == stab_of(k) + 1) begin
            case ($countones(d))
                0: begin
                    m_chg[k] = (m_sel[k] != 8'h00);
                    m_sel[k] = '0; m_idx[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
                end
                1: begin
                    m_chg[k] = (m_sel[k] != d);
                    m_sel[k] = d; m_idx[k] = 3'($clog2(d)); m_vld[k] = 1'b1; m_err[k] = 1'b0;
                end
                default: m_err[k] = 1'b1;
            endcase
        end
    endtask

    // One clock edge: advance the model, then step to 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else begin
            model_edge(0, din_a);
            model_edge(1, din_b);
        end
        #1;
    endtask

    function automatic logic [7:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1, 2:    return 8'(1 << $urandom_range(0, 7));
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [14:0] exp;
        din_a = 8'h04; din_b = 8'h00;
        model_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs_a !== 15'd0 || obs_b !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold c=%0d got a=%h b=%h want 0", c, obs_a, obs_b);
            end
        end
        reset = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 15'd0 : (e == 6) ? mk(8'h04, 3'd2, 1'b1, 1'b1, 1'b0)
                                             : mk(8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL power_on e=%0d got %h want %h", e, obs_a, exp);
            end
            checks++;
            if (obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL power_on_model e=%0d got %h want %h", e, obs_a, exp_w(0));
            end
        end
    endtask

    task automatic test_bounce();
        logic [14:0] exp;
        int pulses = 0;
        logic [7:0] seq [3] = '{8'h10, 8'h04, 8'h10};
        for (int t = 0; t < 2; t++) begin
            din_a = seq[t];
            for (int c = 0; c < 2; c++) begin
                tick();
                pulses += int'(chg_a);
                checks++;
                if (obs_a !== mk(8'h04, 3'd2, 1'b1, 1'b0, 1'b0)) begin
                    errors++;
                    $display("FAIL bounce_toggle t=%0d got %h want %h", t, obs_a,
                             mk(8'h04, 3'd2, 1'b1, 1'b0, 1'b0));
                end
            end
        end
        din_a = seq[2];
        for (int e = 0; e <= 8; e++) begin
            tick();
            pulses += int'(chg_a);
            exp = (e < 6) ? mk(8'h04, 3'd2, 1'b1, 1'b0, 1'b0)
                : (e == 6) ? mk(8'h10, 3'd4, 1'b1, 1'b1, 1'b0)
                           : mk(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_a !== exp || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL bounce_settle e=%0d got %h want %h model %h", e, obs_a, exp, exp_w(0));
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL bounce_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_multibit();
        logic [14:0] exp;
        din_a = 8'h12;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = mk(8'h10, 3'd4, 1'b1, 1'b0, (e >= 6));
            checks++;
            if (obs_a !== exp || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL multibit e=%0d got %h want %h model %h", e, obs_a, exp, exp_w(0));
            end
        end
        din_a = 8'h80;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? mk(8'h10, 3'd4, 1'b1, 1'b0, 1'b1)
                : (e == 6) ? mk(8'h80, 3'd7, 1'b1, 1'b1, 1'b0)
                           : mk(8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_a !== exp || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL multibit_recover e=%0d got %h want %h model %h", e, obs_a, exp, exp_w(0));
            end
        end
    endtask

    task automatic test_blank();
        logic [14:0] exp;
        din_a = 8'h00;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? mk(8'h80, 3'd7, 1'b1, 1'b0, 1'b0)
                : (e == 6) ? mk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0) : 15'd0;
            checks++;
            if (obs_a !== exp || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL blank e=%0d got %h want %h model %h", e, obs_a, exp, exp_w(0));
            end
        end
        din_a = 8'h01;
        tick();
        din_a = 8'h00;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs_a !== 15'd0 || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL blank_glitch c=%0d got %h want 0 model %h", c, obs_a, exp_w(0));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp;
        // Commit non-blank selects first so the async clear is observable.
        din_a = 8'h20; din_b = 8'h08;
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (obs_a !== mk(8'h20, 3'd5, 1'b1, 1'b0, 1'b0) || obs_b !== mk(8'h08, 3'd3, 1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_pre got a=%h b=%h", obs_a, obs_b);
        end
        din_a = 8'h01;
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_a !== 15'd0 || obs_b !== 15'd0) begin
            errors++;
            $display("FAIL reset_async got a=%h b=%h want 0", obs_a, obs_b);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            exp = (e < 6) ? 15'd0 : (e == 6) ? mk(8'h01, 3'd0, 1'b1, 1'b1, 1'b0)
                                             : mk(8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_a !== exp || obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL reset_release e=%0d got %h want %h model %h", e, obs_a, exp, exp_w(0));
            end
            checks++;
            if (obs_b !== exp_w(1)) begin
                errors++;
                $display("FAIL reset_release_b e=%0d got %h want %h", e, obs_b, exp_w(1));
            end
        end
    endtask

    task automatic test_sweep();
        logic [14:0] exp, prev;
        int pulses = 0;
        din_b = 8'h00;
        for (int c = 0; c < 8; c++) tick();
        prev = 15'd0;
        for (int i = 0; i < 8; i++) begin
            din_b = 8'(1 << i);
            for (int e = 0; e < 10; e++) begin
                tick();
                pulses += int'(chg_b);
                exp = (e < 3) ? prev : mk(8'(1 << i), 3'(i), 1'b1, (e == 3), 1'b0);
                checks++;
                if (obs_b !== exp || obs_b !== exp_w(1)) begin
                    errors++;
                    $display("FAIL sweep i=%0d e=%0d got %h want %h model %h", i, e, obs_b, exp, exp_w(1));
                end
            end
            prev = mk(8'(1 << i), 3'(i), 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (pulses !== 8) begin
            errors++;
            $display("FAIL sweep_pulses got %0d want 8", pulses);
        end
    endtask

    task automatic test_random();
        int hold_a = 0;
        int hold_b = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold_a == 0) begin din_a = rand_word(); hold_a = $urandom_range(1, 8); end
            if (hold_b == 0) begin din_b = rand_word(); hold_b = $urandom_range(1, 4); end
            hold_a--;
            hold_b--;
            tick();
            checks++;
            if (obs_a !== exp_w(0)) begin
                errors++;
                $display("FAIL random_a c=%0d din=%h got %h want %h", c, din_a, obs_a, exp_w(0));
            end
            checks++;
            if (obs_b !== exp_w(1)) begin
                errors++;
                $display("FAIL random_b c=%0d din=%h got %h want %h", c, din_b, obs_b, exp_w(1));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        din_a = 8'h00;
        din_b = 8'h00;
        #1 reset = 1'b1;
        test_reset();
        test_bounce();
        test_multibit();
        test_blank();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
